// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous-read memory between instruction fetch and load/store.
// Data has priority; fetch is forced after STREAK_MAX consecutive data grants while it waits.
module mem_arbiter #(
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [12:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [13:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] d_rdata,
    output logic        d_err,
    output logic [13:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out
);

    logic [3:0] streak_q, streak_d;
    logic       if_pend_q, if_pend_d;
    logic       d_pend_q, d_pend_d;
    logic       d_fault_q, d_fault_d;
    logic       d_legal;

    assign d_legal = d_addr[13];

    always_comb begin
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_data_in = '0;
        if (!rst) begin
            if (if_req && (!d_req || streak_q == 4'(STREAK_MAX))) begin
                if_gnt = 1'b1;
            end else if (d_req) begin
                d_gnt = 1'b1;
            end
        end
        if (if_gnt) begin
            mem_addr = {1'b0, if_addr};
        end else if (d_gnt && d_legal) begin
            mem_addr    = d_addr;
            mem_we      = d_we;
            mem_data_in = d_wdata;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && streak_q != 4'(STREAK_MAX)) begin
            streak_d = streak_q + 4'd1;
        end
    end

    // Response owner of the read issued this cycle; stores produce no response.
    always_comb begin
        if_pend_d = if_gnt;
        d_pend_d  = d_gnt && d_legal && !d_we;
        d_fault_d = d_gnt && !d_legal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q  <= '0;
            if_pend_q <= 1'b0;
            d_pend_q  <= 1'b0;
            d_fault_q <= 1'b0;
        end else begin
            streak_q  <= streak_d;
            if_pend_q <= if_pend_d;
            d_pend_q  <= d_pend_d;
            d_fault_q <= d_fault_d;
        end
    end

    assign if_rvalid = if_pend_q;
    assign if_rdata  = if_pend_q ? mem_data_out : 16'h0000;
    assign d_rvalid  = d_pend_q || d_fault_q;
    assign d_err     = d_fault_q;
    assign d_rdata   = d_pend_q ? mem_data_out : 16'h0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory model, directed scenarios and a randomized run checked each cycle
// against a reference model built from fetch-wait counting and a shadow memory.
module tb_mem_arbiter;

    localparam int unsigned SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [12:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [13:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        d_err;
    logic [13:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;

    mem_arbiter #(.STREAK_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    // Environment memory: synchronous read, write on the edge.
    logic [15:0] mem     [0:16383];
    logic [15:0] ref_mem [0:16383];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model state
    int          m_wait;
    int          obs_wait;
    logic        m_if_gnt, m_d_gnt;
    logic        x_if_rv, x_d_rv, x_d_err;
    logic [15:0] x_if_data, x_d_data;

    initial begin
        logic        e_if, e_d, legal;
        logic [13:0] e_addr;
        m_wait = 0; obs_wait = 0; m_if_gnt = 0; m_d_gnt = 0;
        x_if_rv = 0; x_d_rv = 0; x_d_err = 0; x_if_data = 0; x_d_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_if_gnt", if_gnt, 0);
                chk("rst_d_gnt", d_gnt, 0);
                chk("rst_mem_we", mem_we, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_rvalid", {if_rvalid, d_rvalid, d_err}, 0);
                chk("rst_rdata", {if_rdata, d_rdata}, 0);
                m_wait = 0; obs_wait = 0; m_if_gnt = 0; m_d_gnt = 0;
                x_if_rv = 0; x_d_rv = 0; x_d_err = 0; x_if_data = 0; x_d_data = 0;
            end else begin
                chk("if_rvalid", if_rvalid, x_if_rv);
                chk("if_rdata", if_rdata, x_if_rv ? x_if_data : 16'h0);
                chk("d_rvalid", d_rvalid, x_d_rv);
                chk("d_err", d_err, x_d_err);
                chk("d_rdata", d_rdata, x_d_data);
                // Fetch wins when data is absent or it has already waited SMAX cycles.
                e_if  = if_req && (!d_req || m_wait >= int'(SMAX));
                e_d   = d_req && !e_if;
                legal = d_addr >= 14'h2000;
                e_addr = e_if ? {1'b0, if_addr} : ((e_d && legal) ? d_addr : 14'h0);
                chk("if_gnt", if_gnt, e_if);
                chk("d_gnt", d_gnt, e_d);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", mem_we, e_d && legal && d_we);
                if (!e_if && !e_d) chk("idle_wdata", mem_data_in, 0);
                if (e_d && legal && d_we) chk("mem_data_in", mem_data_in, d_wdata);
                x_if_rv   = e_if;
                x_if_data = ref_mem[int'(if_addr)];
                x_d_rv    = e_d && (!legal || !d_we);
                x_d_err   = e_d && !legal;
                x_d_data  = (e_d && legal && !d_we) ? ref_mem[int'(d_addr)] : 16'h0;
                if (e_d && legal && d_we) ref_mem[int'(d_addr)] = d_wdata;
                m_wait   = (if_req && !e_if) ? m_wait + 1 : 0;
                m_if_gnt = e_if;
                m_d_gnt  = e_d;
                if (if_req && !if_gnt) obs_wait++;
                else begin
                    if (if_req) chk("fetch_wait_bound", obs_wait <= int'(SMAX), 1);
                    obs_wait = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 16'(i * 40503);
            ref_mem[i] = 16'(i * 40503);
        end
        mem[4] = 16'hA5C3;       ref_mem[4] = 16'hA5C3;
        mem[14'h100] = 16'h7E57; ref_mem[14'h100] = 16'h7E57;
        rst = 1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        repeat (3) step();
        rst = 0;
        repeat (3) step();

        // Fetch read
        if_req = 1; if_addr = 13'h0004;
        @(negedge clk);
        chk("fetch_gnt", if_gnt, 1);
        chk("fetch_addr", mem_addr, 14'h0004);
        step(); if_req = 0;
        @(negedge clk);
        chk("fetch_rvalid", if_rvalid, 1);
        chk("fetch_rdata", if_rdata, 16'hA5C3);

        // Store then load
        step(); d_req = 1; d_we = 1; d_addr = 14'h2010; d_wdata = 16'h1234;
        @(negedge clk);
        chk("store_gnt", d_gnt, 1);
        chk("store_we", mem_we, 1);
        step(); d_we = 0;
        @(negedge clk);
        chk("load_gnt", d_gnt, 1);
        chk("load_we", mem_we, 0);
        step(); d_req = 0;
        @(negedge clk);
        chk("load_rvalid", d_rvalid, 1);
        chk("load_rdata", d_rdata, 16'h1234);

        // Starvation bound: D,D,D,D,F repeating
        step(); if_req = 1; if_addr = 13'h0040; d_req = 1; d_we = 0; d_addr = 14'h2100;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("starve_pattern", {if_gnt, d_gnt}, (i % 5 == 4) ? 2'b10 : 2'b01);
        end
        step(); if_req = 0; d_req = 0;

        // Illegal data store
        step(); d_req = 1; d_we = 1; d_addr = 14'h0100; d_wdata = 16'hFFFF;
        @(negedge clk);
        chk("illegal_gnt", d_gnt, 1);
        chk("illegal_we", mem_we, 0);
        step(); d_req = 0; if_req = 1; if_addr = 13'h0100;
        @(negedge clk);
        chk("illegal_resp", {d_rvalid, d_err, d_rdata}, {2'b11, 16'h0});
        step(); if_req = 0;
        @(negedge clk);
        chk("illegal_nowrite", if_rdata, 16'h7E57);

        // Reset mid-access with streak saturated
        step(); if_req = 1; if_addr = 13'h0008; d_req = 1; d_we = 0; d_addr = 14'h2010;
        repeat (3) step();
        step(); rst = 1;
        @(negedge clk);
        chk("rst_mid_rvalid", d_rvalid, 0);
        step(); rst = 0;
        @(negedge clk);
        chk("post_rst_grant", {if_gnt, d_gnt}, 2'b01);
        step(); if_req = 0; d_req = 0;
        step();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            step();
            if (rst) rst = 0;
            else if ($urandom_range(0, 199) == 0) rst = 1;
            if (!if_req || m_if_gnt) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 13'($urandom);
            end
            if (!d_req || m_d_gnt) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom);
                d_addr  = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(0, 16'h1FFF))
                                                      : 14'(16'h2000 + $urandom_range(0, 15));
                d_wdata = 16'($urandom);
            end
        end
        step(); rst = 0; if_req = 0; d_req = 0;
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
